// File: rtl/plic_pkg.sv
// Shared address map and register decode for the prioritised PLIC.
package plic_pkg;

  localparam logic [23:0] PRIO_BASE     = 24'h000000;
  localparam logic [23:0] PEND_BASE     = 24'h001000;
  localparam logic [23:0] ENABLE_BASE   = 24'h002000;
  localparam logic [23:0] ENABLE_STRIDE = 24'h000080;
  localparam logic [23:0] ENABLE_END    = 24'h002400;
  localparam logic [23:0] CTX_BASE      = 24'h200000;
  localparam logic [23:0] CTX_STRIDE    = 24'h001000;
  localparam logic [23:0] CTX_END       = 24'h208000;
  localparam logic [23:0] CLAIM_OFS     = 24'h000004;

  localparam int              ID_W    = 6;
  localparam logic [ID_W-1:0] ID_NONE = '0;

  typedef enum logic [2:0] {
    REG_NONE, REG_PRIO, REG_PEND, REG_ENABLE, REG_THRESH, REG_CLAIM
  } reg_sel_e;

  typedef struct packed {
    reg_sel_e   sel;
    logic [2:0] ctx;
    logic [9:0] idx;
  } reg_dec_t;

  // ctx is only meaningful for enable and per-context regions; range checks happen in the top.
  function automatic reg_dec_t decode(input logic [23:0] a);
    reg_dec_t    d;
    logic [23:0] off, inner;
    d.sel = REG_NONE;
    d.ctx = '0;
    d.idx = '0;
    off   = '0;
    inner = '0;
    if (a < PEND_BASE) begin
      d.sel = REG_PRIO;
      d.idx = 10'((a - PRIO_BASE) >> 2);
    end else if (a < PEND_BASE + 24'h8) begin
      d.sel = REG_PEND;
      d.idx = 10'((a - PEND_BASE) >> 2);
    end else if (a >= ENABLE_BASE && a < ENABLE_END) begin
      off   = a - ENABLE_BASE;
      inner = off % ENABLE_STRIDE;
      d.ctx = 3'(off / ENABLE_STRIDE);
      d.idx = 10'(inner >> 2);
      if (inner < 24'h8) d.sel = REG_ENABLE;
    end else if (a >= CTX_BASE && a < CTX_END) begin
      off   = a - CTX_BASE;
      inner = off % CTX_STRIDE;
      d.ctx = 3'(off / CTX_STRIDE);
      if (inner < CLAIM_OFS)              d.sel = REG_THRESH;
      else if (inner < CLAIM_OFS + 24'h4) d.sel = REG_CLAIM;
    end
    return d;
  endfunction

endpackage

// File: rtl/plic_arbiter.sv
// Per-context max tree: highest priority wins, lower ID wins ties, ID 0 when nothing qualifies.
module plic_arbiter
  import plic_pkg::*;
#(
  parameter int NUM_SOURCES = 31,
  parameter int PRIO_BITS   = 3
) (
  input  logic [NUM_SOURCES:0]                cand_i,
  input  logic [NUM_SOURCES:0][PRIO_BITS-1:0] prio_i,
  output logic [ID_W-1:0]                     win_id_o,
  output logic [PRIO_BITS-1:0]                win_prio_o
);

  localparam int LVLS   = $clog2(NUM_SOURCES + 1);
  localparam int LEAVES = 1 << LVLS;

  for (genvar l = 0; l <= LVLS; l++) begin : g_lvl
    localparam int W = LEAVES >> l;
    logic [W-1:0][PRIO_BITS-1:0] p;
    logic [W-1:0][ID_W-1:0]      id;
    for (genvar n = 0; n < W; n++) begin : g_node
      if (l == 0) begin : g_leaf
        if (n <= NUM_SOURCES) begin : g_src
          assign p[n] = cand_i[n] ? prio_i[n] : '0;
        end else begin : g_pad
          assign p[n] = '0;
        end
        assign id[n] = ID_W'(n);
      end else begin : g_cmp
        // Left subtree holds the lower IDs, so the right side needs a strictly higher priority.
        logic take_r;
        assign take_r = g_lvl[l-1].p[2*n+1] > g_lvl[l-1].p[2*n];
        assign p[n]   = take_r ? g_lvl[l-1].p[2*n+1]  : g_lvl[l-1].p[2*n];
        assign id[n]  = take_r ? g_lvl[l-1].id[2*n+1] : g_lvl[l-1].id[2*n];
      end
    end
  end

  assign win_prio_o = g_lvl[LVLS].p[0];
  assign win_id_o   = (win_prio_o == '0) ? ID_NONE : g_lvl[LVLS].id[0];

endmodule

// File: rtl/plic_prio.sv
// Platform-level interrupt controller with priorities, thresholds and a claim/complete gateway.
module plic_prio
  import plic_pkg::*;
#(
  parameter int NUM_SOURCES  = 31,
  parameter int NUM_CONTEXTS = 2,
  parameter int PRIO_BITS    = 3
) (
  input  logic                    clk,
  input  logic                    resetn,
  input  logic                    valid,
  input  logic [23:0]             addr,
  input  logic [3:0]              wmask,
  input  logic [31:0]             wdata,
  output logic [31:0]             rdata,
  output logic                    ready,
  input  logic [NUM_SOURCES-1:0]  interrupt_request,
  output logic [NUM_CONTEXTS-1:0] irq_ctx
);

  localparam int                   NS1      = NUM_SOURCES + 1;
  localparam logic [NUM_SOURCES:0] SRC_MASK = {{NUM_SOURCES{1'b1}}, 1'b0};

  logic [NUM_SOURCES:0][PRIO_BITS-1:0]     prio_q, prio_d;
  logic [NUM_SOURCES:0]                    pend_q, pend_d, infl_q, infl_d, irq_ext;
  logic [NUM_CONTEXTS-1:0][NUM_SOURCES:0]  en_q, en_d;
  logic [NUM_CONTEXTS-1:0][PRIO_BITS-1:0]  thr_q, thr_d, win_prio;
  logic [NUM_CONTEXTS-1:0][ID_W-1:0]       win_id;
  logic                                    ready_q, ready_d, acc, is_wr;
  logic [31:0]                             rdata_q, rdata_d, en_word;
  logic [63:0]                             pend64, en64;
  reg_dec_t                                dec;

  assign irq_ext = {interrupt_request, 1'b0};

  for (genvar c = 0; c < NUM_CONTEXTS; c++) begin : g_ctx
    plic_arbiter #(.NUM_SOURCES(NUM_SOURCES), .PRIO_BITS(PRIO_BITS)) u_arb (
      .cand_i     (pend_q & en_q[c]),
      .prio_i     (prio_q),
      .win_id_o   (win_id[c]),
      .win_prio_o (win_prio[c])
    );
    assign irq_ctx[c] = win_prio[c] > thr_q[c];
  end

  always_comb begin
    dec     = decode(addr);
    acc     = valid && !ready_q;
    is_wr   = |wmask;
    prio_d  = prio_q;
    en_d    = en_q;
    thr_d   = thr_q;
    infl_d  = infl_q;
    pend64  = 64'(pend_q);
    en64    = '0;
    en_word = '0;
    // A source can only re-pend after its previous claim has been completed.
    pend_d  = pend_q | (irq_ext & ~infl_q & SRC_MASK);
    ready_d = acc;
    rdata_d = rdata_q;
    if (acc) begin
      rdata_d = '0;
      case (dec.sel)
        REG_PRIO:
          for (int i = 1; i <= NUM_SOURCES; i++) begin
            if (int'(dec.idx) == i) begin
              if (!is_wr)        rdata_d   = 32'(prio_q[i]);
              else if (wmask[0]) prio_d[i] = wdata[PRIO_BITS-1:0];
            end
          end
        REG_PEND:
          if (!is_wr) rdata_d = dec.idx[0] ? pend64[63:32] : pend64[31:0];
        REG_ENABLE:
          for (int c = 0; c < NUM_CONTEXTS; c++) begin
            if (int'(dec.ctx) == c) begin
              en64    = 64'(en_q[c]);
              en_word = dec.idx[0] ? en64[63:32] : en64[31:0];
              if (!is_wr) begin
                rdata_d = en_word;
              end else begin
                for (int b = 0; b < 4; b++)
                  if (wmask[b]) en_word[8*b +: 8] = wdata[8*b +: 8];
                if (dec.idx[0]) en64[63:32] = en_word;
                else            en64[31:0]  = en_word;
                en_d[c] = NS1'(en64) & SRC_MASK;
              end
            end
          end
        REG_THRESH:
          for (int c = 0; c < NUM_CONTEXTS; c++) begin
            if (int'(dec.ctx) == c) begin
              if (!is_wr)        rdata_d  = 32'(thr_q[c]);
              else if (wmask[0]) thr_d[c] = wdata[PRIO_BITS-1:0];
            end
          end
        REG_CLAIM:
          for (int c = 0; c < NUM_CONTEXTS; c++) begin
            if (int'(dec.ctx) == c) begin
              if (!is_wr) begin
                rdata_d = 32'(win_id[c]);
                // Claim overrides a same-cycle gateway set; in-flight then blocks re-pend.
                for (int i = 1; i <= NUM_SOURCES; i++) begin
                  if (int'(win_id[c]) == i) begin
                    pend_d[i] = 1'b0;
                    infl_d[i] = 1'b1;
                  end
                end
              end else begin
                for (int i = 1; i <= NUM_SOURCES; i++)
                  if (int'(wdata[ID_W-1:0]) == i && en_q[c][i]) infl_d[i] = 1'b0;
              end
            end
          end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      prio_q  <= '0;
      pend_q  <= '0;
      infl_q  <= '0;
      en_q    <= '0;
      thr_q   <= '0;
      ready_q <= 1'b0;
      rdata_q <= '0;
    end else begin
      prio_q  <= prio_d;
      pend_q  <= pend_d;
      infl_q  <= infl_d;
      en_q    <= en_d;
      thr_q   <= thr_d;
      ready_q <= ready_d;
      rdata_q <= rdata_d;
    end
  end

  assign ready = ready_q;
  assign rdata = rdata_q;

endmodule

// File: tb/tb_plic_prio.sv
// Scoreboard bench for plic_prio: a cycle model predicts every cycle, a monitor checks on the far edge.
module tb_plic_prio;

  localparam int NS = 31;
  localparam int NC = 2;
  localparam int PB = 3;

  logic          clk = 1'b0;
  logic          resetn = 1'b1;
  logic          valid = 1'b0;
  logic [23:0]   addr = '0;
  logic [3:0]    wmask = '0;
  logic [31:0]   wdata = '0;
  logic [NS-1:0] src = '0;
  logic [31:0]   rdata;
  logic          ready;
  logic [NC-1:0] irq_ctx;

  plic_prio #(.NUM_SOURCES(NS), .NUM_CONTEXTS(NC), .PRIO_BITS(PB)) dut (
    .clk(clk), .resetn(resetn), .valid(valid), .addr(addr), .wmask(wmask),
    .wdata(wdata), .rdata(rdata), .ready(ready),
    .interrupt_request(src), .irq_ctx(irq_ctx)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit            rdy;
    bit            rd;
    logic [31:0]   rdata;
    logic [NC-1:0] irq;
    string         nm;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   n_chk = 0;
  int   n_fail = 0;

  // Reference state, indexed by source ID (0 unused).
  int m_prio[64];
  bit m_pend[64];
  bit m_infl[64];
  bit m_en[8][64];
  int m_thr[8];
  bit m_ready;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  function automatic void m_reset();
    for (int k = 0; k < 64; k++) begin
      m_prio[k] = 0; m_pend[k] = 0; m_infl[k] = 0;
      for (int c = 0; c < 8; c++) m_en[c][k] = 0;
    end
    for (int c = 0; c < 8; c++) m_thr[c] = 0;
    m_ready = 0;
  endfunction

  function automatic int m_winner(input int c);
    int best, bp;
    best = 0; bp = 0;
    for (int k = 1; k <= NS; k++)
      if (m_pend[k] && m_en[c][k] && m_prio[k] > bp) begin
        best = k; bp = m_prio[k];
      end
    return best;
  endfunction

  function automatic logic [NC-1:0] m_irq();
    logic [NC-1:0] r;
    for (int c = 0; c < NC; c++) r[c] = m_prio[m_winner(c)] > m_thr[c];
    return r;
  endfunction

  // One clock edge of the reference: gateway on old state, then the bus access if accepted.
  function automatic void m_edge(input string nm);
    bit          np[64];
    bit          ni[64];
    bit          acc, rd;
    logic [31:0] rv;
    int          a, c, w, k, id;
    np  = m_pend;
    ni  = m_infl;
    acc = valid && !m_ready;
    rd  = acc && (wmask == 4'd0);
    rv  = '0;
    a   = int'(addr);
    for (k = 1; k <= NS; k++)
      if (src[k-1] && !m_pend[k] && !m_infl[k]) np[k] = 1;
    if (acc) begin
      if (a < 'h1000) begin
        k = a / 4;
        if (k >= 1 && k <= NS) begin
          if (rd) rv = 32'(m_prio[k]);
          else if (wmask[0]) m_prio[k] = int'(wdata[PB-1:0]);
        end
      end else if (a == 'h1000 || a == 'h1004) begin
        w = (a - 'h1000) / 4;
        if (rd)
          for (int b = 0; b < 32; b++)
            if (32*w + b >= 1 && 32*w + b <= NS) rv[b] = m_pend[32*w + b];
      end else if (a >= 'h2000 && a < 'h2400) begin
        c = (a - 'h2000) / 'h80;
        w = ((a - 'h2000) % 'h80) / 4;
        if (c < NC && w < 2)
          for (int b = 0; b < 32; b++) begin
            k = 32*w + b;
            if (k >= 1 && k <= NS) begin
              if (rd) rv[b] = m_en[c][k];
              else if (wmask[b/8]) m_en[c][k] = wdata[b];
            end
          end
      end else if (a >= 'h200000 && a < 'h208000) begin
        c = (a - 'h200000) / 'h1000;
        k = (a - 'h200000) % 'h1000;
        if (c < NC && k == 0) begin
          if (rd) rv = 32'(m_thr[c]);
          else if (wmask[0]) m_thr[c] = int'(wdata[PB-1:0]);
        end else if (c < NC && k == 4) begin
          if (rd) begin
            id = m_winner(c);
            rv = 32'(id);
            if (id != 0) begin np[id] = 0; ni[id] = 1; end
          end else begin
            id = int'(wdata[5:0]);
            if (id >= 1 && id <= NS && m_en[c][id]) ni[id] = 0;
          end
        end
      end
    end
    m_pend  = np;
    m_infl  = ni;
    m_ready = acc;
    sb.push_back('{rdy: acc, rd: rd, rdata: rv, irq: m_irq(), nm: nm});
  endfunction

  task automatic tick(input string nm);
    @(posedge clk);
    m_edge(nm);
    @(negedge clk);
  endtask

  task automatic rd(input logic [23:0] a, input string nm);
    valid = 1'b1; addr = a; wmask = 4'd0;
    tick(nm);
    valid = 1'b0;
    tick(nm);
  endtask

  task automatic wr(input logic [23:0] a, input logic [31:0] d, input logic [3:0] m, input string nm);
    valid = 1'b1; addr = a; wdata = d; wmask = m;
    tick(nm);
    valid = 1'b0; wmask = 4'd0;
    tick(nm);
  endtask

  always @(negedge clk) begin
    if (resetn && sb.size() > 0) begin
      mon_e = sb.pop_front();
      chk({mon_e.nm, " ready"}, 32'(ready), 32'(mon_e.rdy));
      if (mon_e.rd) chk({mon_e.nm, " rdata"}, rdata, mon_e.rdata);
      chk({mon_e.nm, " irq_ctx"}, 32'(irq_ctx), 32'(mon_e.irq));
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int unsigned a;
    logic [31:0] d;
    #2 resetn = 1'b0;
    #10;
    chk("rst ready", 32'(ready), 32'd0);
    chk("rst rdata", rdata, 32'd0);
    chk("rst irq_ctx", 32'(irq_ctx), 32'd0);
    @(negedge clk);
    resetn = 1'b1;
    m_reset();

    for (int k = 0; k <= NS + 1; k++) rd(24'(4*k), "rst_prio");
    rd(24'h001000, "rst_pend0");
    rd(24'h001004, "rst_pend1");
    for (int c = 0; c < NC; c++) begin
      rd(24'(32'h2000 + 32'h80*c), "rst_en_w0");
      rd(24'(32'h2004 + 32'h80*c), "rst_en_w1");
      rd(24'(32'h200000 + 32'h1000*c), "rst_thr");
      rd(24'(32'h200004 + 32'h1000*c), "rst_claim");
    end

    wr(24'h00000c, 32'd2, 4'hf, "t2_prio3");
    wr(24'h000014, 32'd2, 4'hf, "t2_prio5");
    wr(24'h002000, 32'h28, 4'hf, "t2_en0");
    wr(24'h200000, 32'd1, 4'hf, "t2_thr0");
    src[2] = 1'b1; src[4] = 1'b1;
    tick("t2_raise");
    rd(24'h200004, "t2_claim_a");
    rd(24'h200004, "t2_claim_b");
    rd(24'h200004, "t2_claim_c");

    wr(24'h00001c, 32'd1, 4'hf, "t3_prio7");
    wr(24'h201000, 32'd1, 4'hf, "t3_thr1");
    wr(24'h002080, 32'h80, 4'hf, "t3_en1");
    src[6] = 1'b1;
    tick("t3_raise");
    rd(24'h001000, "t3_pend");
    rd(24'h201004, "t3_claim1");

    wr(24'h000010, 32'd3, 4'hf, "t4_prio4");
    wr(24'h002000, 32'h38, 4'hf, "t4_en0");
    src[3] = 1'b1;
    tick("t4_raise");
    rd(24'h200004, "t4_claim");
    for (int i = 0; i < 10; i++) rd(24'h001000, "t4_blocked");
    wr(24'h200004, 32'd4, 4'hf, "t4_complete");
    rd(24'h001000, "t4_repend");
    rd(24'h200004, "t4_reclaim");

    wr(24'h201004, 32'd4, 4'hf, "t5_cmp_wrong_ctx");
    wr(24'h200004, 32'd0, 4'hf, "t5_cmp_id0");
    wr(24'h200004, 32'd40, 4'hf, "t5_cmp_id40");
    repeat (3) tick("t5_idle");
    rd(24'h001000, "t5_still_blocked");
    wr(24'h200004, 32'd4, 4'hf, "t5_cmp_ok");
    rd(24'h001000, "t5_pend");

    wr(24'h000008, 32'hff, 4'b0001, "t6_bytewr");
    rd(24'h000008, "t6_prio2");
    wr(24'h000008, 32'h0000_0100, 4'b0010, "t6_hibyte");
    rd(24'h000008, "t6_prio2_keep");
    wr(24'h202000, 32'd5, 4'hf, "t6_thr_ctx2");
    rd(24'h202000, "t6_thr_ctx2");
    wr(24'h002100, 32'hffff_ffff, 4'hf, "t6_en_ctx2");
    rd(24'h002100, "t6_en_ctx2");
    wr(24'h002000, 32'hffff_ffff, 4'hf, "t6_en_all");
    rd(24'h002000, "t6_en_bit0");
    rd(24'h002004, "t6_en_hi");
    rd(24'h00a000, "t6_unmapped");

    valid = 1'b1; addr = 24'h000008; wmask = 4'd0;
    repeat (5) tick("held_valid");
    valid = 1'b0;
    tick("held_idle");

    for (int i = 0; i < 300; i++) begin
      if ($urandom_range(3) == 0) src = NS'($urandom);
      case ($urandom_range(5))
        0:       a = 4 * $urandom_range(40);
        1:       a = 32'h1000 + 4 * $urandom_range(1);
        2:       a = 32'h2000 + 32'h80 * $urandom_range(2) + 4 * $urandom_range(1);
        3:       a = 32'h200000 + 32'h1000 * $urandom_range(2);
        default: a = 32'h200004 + 32'h1000 * $urandom_range(2);
      endcase
      if ($urandom_range(1) == 0) begin
        rd(24'(a), "rnd_rd");
      end else begin
        d = $urandom;
        if ($urandom_range(1) == 0) d = 32'($urandom_range(40));
        wr(24'(a), d, 4'($urandom_range(1, 15)), "rnd_wr");
      end
    end

    valid = 1'b1; addr = 24'h200004; wmask = 4'd0;
    @(posedge clk);
    #1;
    chk("midrst ack", 32'(ready), 32'd1);
    resetn = 1'b0;
    #1;
    chk("midrst ready", 32'(ready), 32'd0);
    chk("midrst rdata", rdata, 32'd0);
    chk("midrst irq_ctx", 32'(irq_ctx), 32'd0);
    valid = 1'b0;
    @(negedge clk);
    resetn = 1'b1;
    m_reset();
    rd(24'h00000c, "post_rst_prio3");
    rd(24'h002000, "post_rst_en0");
    rd(24'h200000, "post_rst_thr0");
    rd(24'h001000, "post_rst_pend");

    @(negedge clk);
    #1;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/plic_prio.md
Name: plic_prio

Overview:
Parametrised platform-level interrupt controller, successor to the two-context, enable-only PLIC. Adds:
- per-source priorities;
- per-context thresholds;
- a level-sensitive gateway with in-flight tracking, so a source cannot re-pend until completed;
- a configurable source and context count.

It sits on the SoC MMIO bus and drives the external-interrupt lines of the hart contexts (M/S per hart).

Parameters:
NUM_SOURCES, 31, number of interrupt sources (IDs 1..NUM_SOURCES, legal 1..63); ID 0 is reserved as "none".
NUM_CONTEXTS, 2, number of target contexts (legal 1..8).
PRIO_BITS, 3, priority and threshold width (legal 1..8).

Ports:
clk  in  1  system clock
resetn  in  1  asynchronous active-low reset
valid  in  1  bus request
addr  in  24  byte offset within the PLIC window
wmask  in  4  byte write strobes; any bit set means write, all zero means read
wdata  in  32  write data
rdata  out  32  read data, registered, valid while ready=1
ready  out  1  one-cycle acknowledge
interrupt_request  in  NUM_SOURCES  level interrupt inputs; bit k-1 is source ID k
irq_ctx  out  NUM_CONTEXTS  interrupt notification per context

Behaviour:
Reset and bus handshake
- Reset: one clock (clk); asynchronous active-low reset (resetn). All priorities, enables, thresholds, pending and in-flight bits clear. ready=0, rdata=0, irq_ctx=0.
- Accept occurs when valid && !ready. ready rises the next cycle for exactly one cycle. A request held valid is accepted once, then re-accepted on the cycle after ready drops.
- Writes and read side effects commit at the accept edge. rdata is loaded at the same edge.

Register map (32-bit words, byte-masked writes)
- 0x000000+4*k: priority[k], low PRIO_BITS bits. k=0 and k>NUM_SOURCES read 0 and ignore writes.
- 0x001000+4*w: pending bits 32w..32w+31, w=0..1. Read-only; bit 0 is always 0.
- 0x002000+0x80*c+4*w: enable for context c. Bit 0 and bits above NUM_SOURCES are hardwired 0.
- 0x200000+0x1000*c: threshold[c].
- 0x200004+0x1000*c: claim (read) / complete (write) for context c.
- Unmapped addresses and c>=NUM_CONTEXTS: read 0, writes ignored. ready is still returned.

Gateway (per source)
- pending[k] sets when interrupt_request is high and pending[k]==0 and inflight[k]==0.
- Latency: source high at edge t gives pending=1 after edge t and irq_ctx after edge t (irq_ctx is combinational from state).

Arbitration (per context c)
- Candidate set: pending & enable[c] & (priority>0).
- Winner: highest priority; ties go to the lowest ID. No candidate gives ID 0.
- irq_ctx[c] = (winner priority > threshold[c]).

Claim and complete
- Claim read returns the winner regardless of threshold. If the ID is nonzero, the same edge clears pending[ID] and sets inflight[ID].
- Complete write: wdata[5:0]=ID clears inflight[ID] only if 1<=ID<=NUM_SOURCES and enable[c][ID]=1. Otherwise the write is silently ignored.
- Priority 0 source: may pend, never notifies, never claimed.

Simultaneous events
- Claim and gateway set on the same ID in the same cycle: claim wins, and in-flight blocks the re-pend.
- Complete while the source is still high: pending re-sets at the next edge (1-cycle gap).
- Changing enable or priority while pending: the arbiter re-evaluates combinationally. Pending state is untouched.
- Reset asserted mid-transaction: immediate clear, ready drops asynchronously, and the transaction is lost.

Decomposition:
Package plic_pkg holds:
- address base constants (PRIO_BASE, PEND_BASE, ENABLE_BASE, ENABLE_STRIDE=0x80, CTX_BASE, CTX_STRIDE=0x1000, CLAIM_OFS=4);
- the reserved ID 0 constant;
- a function decoding context index from addr.

Sub-module plic_arbiter (parameters NUM_SOURCES, PRIO_BITS) takes the candidate vector and the flattened priorities. It outputs winner ID and winner priority through a combinational max tree with a lowest-ID tie-break. It is instantiated once per context via generate.

Test Plan:
1. Reset, then read every mapped register -> all 0; irq_ctx=0; ready pulses once per valid.
2. prio[3]=2, prio[5]=2, enable ctx0 = 0x28, threshold0=1; raise sources 3 and 5 -> irq_ctx[0]=1 one edge later; claim0 reads 3 then 5, then 0; irq_ctx[0]=0 after the second claim.
3. prio[7]=1, threshold1=1, enable ctx1 bit 7, source 7 high -> pending bit 7=1, irq_ctx[1]=0, claim1 returns 7.
4. Source 4 held high, claimed, not completed -> pending stays 0 for 20 cycles; complete 4 on ctx0 -> pending 4 = 1 one edge later.
5. Complete ID 4 on a context with enable bit 4 = 0 -> inflight unchanged, source stays blocked; complete ID 0 and ID 40 (NUM_SOURCES=31) -> ignored.
6. Byte write wmask=0001 of 0xFF to priority[2] -> reads 7 (PRIO_BITS=3); write to ctx 2 (NUM_CONTEXTS=2) -> ignored, reads 0; assert resetn low mid-access -> ready=0 immediately.
